// File: rtl/vga_timing.sv
// VGA raster timing generator: divides clk down to a pixel strobe and walks
// hcount/vcount over the full frame, with registered sync and blank flags.
module vga_timing #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  output logic        pix_en,
  output logic [10:0] hcount,
  output logic [10:0] vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        hblank,
  output logic        vblank,
  output logic        blank,
  output logic        frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
  localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [3:0]  div_cnt;
  logic        h_wrap;
  logic [10:0] h_next;
  logic [10:0] v_next;

  assign pix_en      = reset_n && en && (div_cnt == DIV_LAST);
  assign frame_start = pix_en && (hcount == 11'd0) && (vcount == 11'd0);

  always_comb begin
    h_wrap = (hcount == H_LAST);
    h_next = h_wrap ? 11'd0 : hcount + 11'd1;
    v_next = vcount;
    if (h_wrap) v_next = (vcount == V_LAST) ? 11'd0 : vcount + 11'd1;
  end

  // Flags are decoded from the next counts so they land on the same edge as
  // the counts they describe; no skew between counts and flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_cnt <= 4'd0;
      hcount  <= 11'd0;
      vcount  <= 11'd0;
      hsync   <= 1'b1;
      vsync   <= 1'b1;
      hblank  <= 1'b0;
      vblank  <= 1'b0;
      blank   <= 1'b0;
    end else if (en) begin
      div_cnt <= (div_cnt == DIV_LAST) ? 4'd0 : div_cnt + 4'd1;
      if (pix_en) begin
        hcount <= h_next;
        vcount <= v_next;
        hsync  <= !((h_next >= HS_BEG) && (h_next < HS_END));
        vsync  <= !((v_next >= VS_BEG) && (v_next < VS_END));
        hblank <= (h_next >= H_VIS);
        vblank <= (v_next >= V_VIS);
        blank  <= (h_next >= H_VIS) || (v_next >= V_VIS);
      end
    end
  end
endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing: default timing, CLK_DIV=1, and a tiny
// raster (CLK_DIV=3, 8x6) for table-driven and full-frame checks.
module tb_vga_timing;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic en = 1'b0;
  always #5 clk = ~clk;

  logic        d0_pix, d0_fs, d0_hs, d0_vs, d0_hb, d0_vb, d0_bl;
  logic [10:0] d0_hc, d0_vc;
  logic        d1_pix, d1_fs, d1_hs, d1_vs, d1_hb, d1_vb, d1_bl;
  logic [10:0] d1_hc, d1_vc;
  logic        d2_pix, d2_fs, d2_hs, d2_vs, d2_hb, d2_vb, d2_bl;
  logic [10:0] d2_hc, d2_vc;

  vga_timing u_d0 (
    .clk(clk), .reset_n(reset_n), .en(en), .pix_en(d0_pix),
    .hcount(d0_hc), .vcount(d0_vc), .hsync(d0_hs), .vsync(d0_vs),
    .hblank(d0_hb), .vblank(d0_vb), .blank(d0_bl), .frame_start(d0_fs));

  vga_timing #(.CLK_DIV(1)) u_d1 (
    .clk(clk), .reset_n(reset_n), .en(en), .pix_en(d1_pix),
    .hcount(d1_hc), .vcount(d1_vc), .hsync(d1_hs), .vsync(d1_vs),
    .hblank(d1_hb), .vblank(d1_vb), .blank(d1_bl), .frame_start(d1_fs));

  // Tiny raster: H = 4+1+2+1 = 8 (hsync low 5..6), V = 3+1+1+1 = 6 (vsync low 4)
  vga_timing #(.CLK_DIV(3), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
               .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)) u_d2 (
    .clk(clk), .reset_n(reset_n), .en(en), .pix_en(d2_pix),
    .hcount(d2_hc), .vcount(d2_vc), .hsync(d2_hs), .vsync(d2_vs),
    .hblank(d2_hb), .vblank(d2_vb), .blank(d2_bl), .frame_start(d2_fs));

  typedef struct {
    logic rst, en;
    int   n;
    logic pix, fs;
    int   hc, vc;
    logic hs, vs, hb, vb, bl;
  } vec_t;

  vec_t tbl[12];
  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] obs(input logic pix, fs, input logic [10:0] hc, vc,
                                      input logic hs, vs, hb, vb, bl);
    return 64'({pix, fs, hc, vc, hs, vs, hb, vb, bl});
  endfunction

  // reset-state pattern: pix 0, fs 0, counts 0, syncs 1, blanks 0
  localparam logic [63:0] RST_OBS = 64'({1'b0, 1'b0, 11'd0, 11'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});

  initial begin
    int hb_t, hb_hc, hs_lo, hs_first, hs_last, pix0, pix1, err0, err2;
    int fs_cnt, fs_first, fs_second, vb_rise, vb_bad;
    logic d0_pix_t0, d0_fs_t1, d1_fs_t0, prev_vb;
    logic [63:0] snap;
    int frz_err;

    tbl[0]  = '{1,1,2,  1,1,0,0,1,1,0,0,0};
    tbl[1]  = '{1,1,1,  0,0,1,0,1,1,0,0,0};
    tbl[2]  = '{1,1,8,  1,0,3,0,1,1,0,0,0};
    tbl[3]  = '{1,1,1,  0,0,4,0,1,1,1,0,1};
    tbl[4]  = '{1,1,3,  0,0,5,0,0,1,1,0,1};
    tbl[5]  = '{1,0,5,  0,0,5,0,0,1,1,0,1};
    tbl[6]  = '{1,1,5,  1,0,6,0,0,1,1,0,1};
    tbl[7]  = '{1,1,1,  0,0,7,0,1,1,1,0,1};
    tbl[8]  = '{1,1,3,  0,0,0,1,1,1,0,0,0};
    tbl[9]  = '{1,1,15, 0,0,5,1,0,1,1,0,1};
    tbl[10] = '{0,1,1,  0,0,0,0,1,1,0,0,0};
    tbl[11] = '{0,1,4,  0,0,0,0,1,1,0,0,0};

    // Reset held 5 clocks with en high
    reset_n = 1'b0; en = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("reset_d0", obs(d0_pix, d0_fs, d0_hc, d0_vc, d0_hs, d0_vs, d0_hb, d0_vb, d0_bl), RST_OBS);
    check("reset_d1", obs(d1_pix, d1_fs, d1_hc, d1_vc, d1_hs, d1_vs, d1_hb, d1_vb, d1_bl), RST_OBS);
    check("reset_d2", obs(d2_pix, d2_fs, d2_hc, d2_vc, d2_hs, d2_vs, d2_hb, d2_vb, d2_bl), RST_OBS);

    for (int i = 0; i < 12; i++) begin
      reset_n = tbl[i].rst;
      en      = tbl[i].en;
      repeat (tbl[i].n) @(posedge clk);
      #1;
      check($sformatf("table_row%0d", i),
            obs(d2_pix, d2_fs, d2_hc, d2_vc, d2_hs, d2_vs, d2_hb, d2_vb, d2_bl),
            obs(tbl[i].pix, tbl[i].fs, 11'(tbl[i].hc), 11'(tbl[i].vc),
                tbl[i].hs, tbl[i].vs, tbl[i].hb, tbl[i].vb, tbl[i].bl));
    end

    // Default timing and CLK_DIV=1: two full lines from reset release
    reset_n = 1'b0; en = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b1; #1;
    hb_t = -1; hb_hc = -1; hs_lo = 0; hs_first = -1; hs_last = -1;
    pix0 = 0; pix1 = 0; err0 = 0;
    d0_pix_t0 = 1'b1; d0_fs_t1 = 1'b0; d1_fs_t0 = 1'b0;
    for (int t = 0; t <= 3200; t++) begin
      if (d0_hc != 11'((t / 2) % 800) || d0_vc != 11'(t / 1600)) err0++;
      if (d0_hs != !(d0_hc >= 656 && d0_hc < 752) || d0_hb != (d0_hc >= 640)
          || d0_bl != (d0_hb | d0_vb) || d0_vb != 1'b0 || d0_vs != 1'b1) err0++;
      if (t == 0) begin d0_pix_t0 = d0_pix; d1_fs_t0 = d1_fs; end
      if (t == 1) d0_fs_t1 = d0_fs;
      if (hb_t < 0 && d0_hb) begin hb_t = t; hb_hc = int'(d0_hc); end
      if (t < 1600) begin
        pix0 += int'(d0_pix);
        pix1 += int'(d1_pix);
        if (!d0_hs) begin
          hs_lo++;
          if (hs_first < 0) hs_first = int'(d0_hc);
          hs_last = int'(d0_hc);
        end
      end
      if (t == 1599) check("d0_line_end", {d0_hc, d0_vc}, {11'd799, 11'd0});
      if (t == 1600) check("d0_line_wrap", {d0_hc, d0_vc}, {11'd0, 11'd1});
      if (t == 800)  check("d1_line_wrap", {d1_hc, d1_vc}, {11'd0, 11'd1});
      if (t == 1600) check("d1_line2_wrap", {d1_hc, d1_vc}, {11'd0, 11'd2});
      if (t < 3200) begin @(posedge clk); #1; end
    end
    check("d0_model", err0, 0);
    check("d0_first_pix_delay", {d0_pix_t0, d0_fs_t1}, 2'b01);
    check("d1_first_fs", d1_fs_t0, 1'b1);
    check("hblank_rise", {32'(hb_t), 32'(hb_hc)}, {32'd1280, 32'd640});
    check("hsync_low_clk", hs_lo, 192);
    check("hsync_span", {32'(hs_first), 32'(hs_last)}, {32'd656, 32'd751});
    check("d0_pix_per_line", pix0, 800);
    check("d1_pix_const", pix1, 1600);
    check("d0_line2", {d0_hc, d0_vc}, {11'd0, 11'd2});

    // Freeze at hcount 100 for 50 clocks
    for (int i = 0; i < 400 && d0_hc != 11'd100; i++) begin @(posedge clk); #1; end
    check("freeze_reach", d0_hc, 11'd100);
    snap = 64'({d0_hc, d0_vc, d0_hs, d0_vs, d0_hb, d0_vb, d0_bl});
    en = 1'b0; #1;
    frz_err = 0;
    for (int i = 0; i < 50; i++) begin
      if (d0_pix || d1_pix || d2_pix) frz_err++;
      if (64'({d0_hc, d0_vc, d0_hs, d0_vs, d0_hb, d0_vb, d0_bl}) !== snap) frz_err++;
      @(posedge clk); #1;
    end
    check("freeze_hold", frz_err, 0);
    en = 1'b1; #1;
    check("freeze_resume_pos", d0_hc, 11'd100);
    repeat (2) @(posedge clk); #1;
    check("freeze_resume_step", d0_hc, 11'd101);

    // Tiny raster: 300 clocks (just over two 144-clock frames)
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1; #1;
    err2 = 0; fs_cnt = 0; fs_first = -1; fs_second = -1; vb_rise = 0; vb_bad = 0;
    prev_vb = 1'b0;
    for (int t = 0; t < 300; t++) begin
      if (d2_hc != 11'((t / 3) % 8) || d2_vc != 11'((t / 24) % 6)) err2++;
      if (d2_hs != !(d2_hc >= 5 && d2_hc < 7) || d2_vs != (d2_vc != 4)
          || d2_hb != (d2_hc >= 4) || d2_vb != (d2_vc >= 3) || d2_bl != (d2_hb | d2_vb)) err2++;
      if (d2_fs) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = t; else if (fs_second < 0) fs_second = t;
      end
      if (d2_vb && !prev_vb) begin
        vb_rise++;
        if (d2_vc != 11'd3) vb_bad++;
      end
      prev_vb = d2_vb;
      @(posedge clk); #1;
    end
    check("d2_frame_model", err2, 0);
    check("d2_frame_start", {32'(fs_first), 32'(fs_second - fs_first), 32'(fs_cnt)},
          {32'd2, 32'd144, 32'd3});
    check("d2_vblank_rise", {32'(vb_rise), 32'(vb_bad)}, {32'd2, 32'd0});

    // Reset from inside both sync pulses
    for (int i = 0; i < 200 && !(d2_vc == 11'd4 && d2_hc == 11'd5); i++) begin
      @(posedge clk); #1;
    end
    check("midsync_reach", {d2_hc, d2_vc, d2_hs, d2_vs, d2_bl}, {11'd5, 11'd4, 1'b0, 1'b0, 1'b1});
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("midsync_reset", obs(d2_pix, d2_fs, d2_hc, d2_vc, d2_hs, d2_vs, d2_hb, d2_vb, d2_bl), RST_OBS);
    check("midsync_reset_d1", obs(d1_pix, d1_fs, d1_hc, d1_vc, d1_hs, d1_vs, d1_hb, d1_vb, d1_bl), RST_OBS);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameter CLK_DIV, default 2: number of clk cycles per pixel; legal range 1..15.
REQ-002 Parameter H_ACTIVE, default 640: visible pixels per line.
REQ-003 Parameter H_FP, default 16; H_SYNC, default 96; H_BP, default 48: horizontal front porch, sync and back porch, in pixels.
REQ-004 Parameter V_ACTIVE, default 480: visible lines per frame.
REQ-005 Parameter V_FP, default 10; V_SYNC, default 2; V_BP, default 33: vertical front porch, sync and back porch, in lines.
REQ-006 Port clk  input  1  system clock (50 MHz on Nexys2).
REQ-007 Port reset_n  input  1  one clock; reset is synchronous and active-low.
REQ-008 Port en  input  1  timing run enable; low freezes all counters.
REQ-009 Port pix_en  output  1  pixel strobe, one clk wide.
REQ-010 Port hcount  output  11  current pixel column, 0..H_TOTAL-1.
REQ-011 Port vcount  output  11  current line, 0..V_TOTAL-1.
REQ-012 Port hsync / vsync  output  1 each  sync pulses, active-low.
REQ-013 Port hblank / vblank / blank  output  1 each  horizontal, vertical and combined blanking, active-high.
REQ-014 Port frame_start  output  1  one-clk pulse marking pixel (0,0).

Function
REQ-015 H_TOTAL SHALL equal H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default); V_TOTAL SHALL equal V_ACTIVE+V_FP+V_SYNC+V_BP (525 by default).
REQ-016 Internal div_cnt (4 bits) SHALL count 0..CLK_DIV-1 and wrap to 0 on clk edges where en=1; it SHALL hold where en=0.
REQ-017 pix_en SHALL be high exactly in cycles where div_cnt==CLK_DIV-1 and en=1; with CLK_DIV=1 it SHALL be high whenever en=1.
REQ-018 hcount SHALL increment on each clk edge where pix_en=1; at H_TOTAL-1 it SHALL wrap to 0.
REQ-019 vcount SHALL increment only on the edge where hcount wraps; at V_TOTAL-1 it SHALL wrap to 0 on that same edge.
REQ-020 hsync, vsync, hblank, vblank and blank SHALL be registered and consistent with the hcount/vcount values presented in the same cycle; there SHALL be no pipeline skew between counts and flags.
REQ-021 hsync SHALL be 0 iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (656..751 by default).
REQ-022 vsync SHALL be 0 iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (490..491 by default).
REQ-023 hblank SHALL be 1 iff hcount >= H_ACTIVE; vblank SHALL be 1 iff vcount >= V_ACTIVE; blank SHALL equal hblank OR vblank.
REQ-024 vblank SHALL rise exactly once per frame, on the edge where vcount becomes V_ACTIVE, and SHALL be glitch-free, because paddle logic uses it as its update edge.
REQ-025 frame_start SHALL be high exactly in cycles where pix_en=1, hcount==0 and vcount==0; one pulse per frame.
REQ-026 When en falls mid-line, all outputs except pix_en and frame_start SHALL hold their values; counting SHALL resume from the held position when en returns to 1.
REQ-027 Count arithmetic SHALL be 11-bit unsigned, and the counters SHALL never present values >= H_TOTAL or >= V_TOTAL.

Reset
REQ-028 When reset_n=0 at a clk edge, the block SHALL set div_cnt=0, hcount=0, vcount=0, hsync=1, vsync=1, hblank=0, vblank=0 and blank=0; pix_en and frame_start SHALL read 0 while reset_n=0.
REQ-029 Reset SHALL take priority over en and SHALL act from any state, including mid-sync and mid-blank.
REQ-030 After reset_n rises with en=1, the first pix_en SHALL occur CLK_DIV-1 cycles later, and frame_start SHALL accompany it.

Verification
REQ-031 Scenario: hold reset_n=0 for 5 clk -> hcount=0, vcount=0, hsync=1, vsync=1, blank=0, pix_en=0.
REQ-032 Scenario: defaults, run 1 line -> hblank rises at hcount=640; hsync low for hcount 656..751 (192 clk); hcount 799->0 with vcount 0->1; line period 1600 clk.
REQ-033 Scenario: run a full frame -> vblank rises at vcount 480; vsync low on lines 490..491; vcount 524->0; frame period 840000 clk; exactly one frame_start per frame.
REQ-034 Scenario: drop en at hcount=100 for 50 clk -> all counts and flags frozen for those 50 clk; no pix_en; counting resumes at hcount 100.
REQ-035 Scenario: assert reset_n=0 at vcount=300, hcount=700 -> all outputs at reset values on the next cycle.
REQ-036 Scenario: CLK_DIV=1 -> pix_en is constantly high; line period 800 clk; frame period 420000 clk.
